edge_detect_bank: RTL and testbench

EDGE_DETECT_BANK -- requirements
Module: edge_detect_bank

---
 rtl/edge_detect_pkg.sv | 14 +
 rtl/edge_detect_chan.sv | 95 +++++++++
 rtl/edge_detect_bank.sv | 40 ++++
 tb/tb_edge_detect_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared constants for the edge detector bank: MODE selector strings and the
// debounce counter width helper.
package edge_detect_pkg;

  localparam string MODE_RISING  = "RISING";
  localparam string MODE_FALLING = "FALLING";
  localparam string MODE_BOTH    = "BOTH";

  // Counter wide enough to hold DEBOUNCE_CYCLES-1 with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 32'd1;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel of the edge detector bank: synchroniser chain, optional debounce
// filter, MODE-qualified edge pulse and a sticky event flag.
// Optional debounce filter is compiled in by defining EDGE_DETECT_DEBOUNCE_EN.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int    SYNC_STAGES     = 2,
  parameter string MODE            = "BOTH",
  parameter int    DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic flag_clr,
  output logic pulse,
  output logic level,
  output logic flag
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_detect_chan: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("edge_detect_chan: DEBOUNCE_CYCLES must be at least 1");
  end
  if (!((MODE == MODE_RISING) || (MODE == MODE_FALLING) || (MODE == MODE_BOTH))) begin : g_bad_mode
    $error("edge_detect_chan: MODE must be RISING, FALLING or BOTH");
  end

  localparam logic DET_RISE = (MODE == MODE_RISING)  || (MODE == MODE_BOTH);
  localparam logic DET_FALL = (MODE == MODE_FALLING) || (MODE == MODE_BOTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_d;
  logic                   pulse_d;

  // Synchroniser chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Accept a new level only after it has disagreed with the current one for
  // DEBOUNCE_CYCLES consecutive cycles; the counter restarts on acceptance.
  always_comb begin
    level_d = level;
    cnt_d   = '0;
    if (sync != level) begin
      if (cnt_q == CNT_LAST) level_d = sync;
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Without the filter the level simply follows the synchronised input.
  always_comb begin
    level_d = sync;
  end
`endif

  // Pulse is computed from the upcoming level change so it registers on the
  // same edge as the level itself.
  always_comb begin
    pulse_d = (DET_RISE & level_d & ~level) | (DET_FALL & ~level_d & level);
  end

  // Level, pulse and sticky flag registers; a pulse overrides a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      pulse <= 1'b0;
      flag  <= 1'b0;
    end else begin
      level <= level_d;
      pulse <= pulse_d;
      flag  <= pulse | (flag & ~flag_clr);
    end
  end

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of WIDTH independent edge detector channels.
// Optional debounce filter is compiled in by defining EDGE_DETECT_DEBOUNCE_EN.
module edge_detect_bank
  import edge_detect_pkg::*;
#(
  parameter int    WIDTH           = 8,
  parameter int    SYNC_STAGES     = 2,
  parameter string MODE            = "BOTH",
  parameter int    DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] flag,
  input  logic [WIDTH-1:0] flag_clr
);

  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("edge_detect_bank: WIDTH must be in 1..32");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .MODE            (MODE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .in       (in[i]),
      .flag_clr (flag_clr[i]),
      .pulse    (pulse[i]),
      .level    (level[i]),
      .flag     (flag[i])
    );
  end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Scoreboard bench for edge_detect_bank: three instances (RISING, FALLING,
// BOTH) share the same stimulus; a history-based model predicts outputs.
module tb_edge_detect_bank;

  localparam int W = 8;
  localparam int S = 2;
  localparam int DCYC = 4;
`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int DB = DCYC;
`else
  localparam int DB = 1;
`endif

  typedef struct packed {
    logic [W-1:0]        level;
    logic [2:0][W-1:0]   pulse;
    logic [2:0][W-1:0]   flag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_v = '0;
  logic [W-1:0] clr = '0;
  logic [W-1:0] pulse_o [3];
  logic [W-1:0] level_o [3];
  logic [W-1:0] flag_o  [3];

  int n_chk  = 0;
  int n_fail = 0;

  exp_t         exp_q [$];
  logic [W-1:0] hist  [$];
  logic [W-1:0]      m_level = '0;
  logic [2:0][W-1:0] m_pulse = '0;
  logic [2:0][W-1:0] m_flag  = '0;
  string mname [3] = '{"RISING", "FALLING", "BOTH"};

  always #5 clk = ~clk;

  edge_detect_bank #(.WIDTH(W), .SYNC_STAGES(S), .MODE("RISING"), .DEBOUNCE_CYCLES(DCYC)) u_rise (
    .clk(clk), .rst(rst), .in(in_v), .pulse(pulse_o[0]), .level(level_o[0]),
    .flag(flag_o[0]), .flag_clr(clr));
  edge_detect_bank #(.WIDTH(W), .SYNC_STAGES(S), .MODE("FALLING"), .DEBOUNCE_CYCLES(DCYC)) u_fall (
    .clk(clk), .rst(rst), .in(in_v), .pulse(pulse_o[1]), .level(level_o[1]),
    .flag(flag_o[1]), .flag_clr(clr));
  edge_detect_bank #(.WIDTH(W), .SYNC_STAGES(S), .MODE("BOTH"), .DEBOUNCE_CYCLES(DCYC)) u_both (
    .clk(clk), .rst(rst), .in(in_v), .pulse(pulse_o[2]), .level(level_o[2]),
    .flag(flag_o[2]), .flag_clr(clr));

  // Reference model: the filtered level flips once the input seen S edges ago
  // and the DB-1 samples before it all disagree with the current level.
  always @(posedge clk) begin : model
    exp_t         e;
    logic [W-1:0] nl;
    logic         all_diff;
    logic         v;
    if (rst) begin
      hist.delete();
      m_level = '0;
      m_pulse = '0;
      m_flag  = '0;
    end else begin
      hist.push_front(in_v);
      if (hist.size() > S + DB + 1) void'(hist.pop_back());
      nl = m_level;
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          v = (S + j < hist.size()) ? hist[S + j][c] : 1'b0;
          if (v == m_level[c]) all_diff = 1'b0;
        end
        if (all_diff) nl[c] = ~m_level[c];
      end
      for (int m = 0; m < 3; m++) m_flag[m] = m_pulse[m] | (m_flag[m] & ~clr);
      m_pulse[0] = nl & ~m_level;
      m_pulse[1] = ~nl & m_level;
      m_pulse[2] = nl ^ m_level;
      m_level    = nl;
    end
    e.level = m_level;
    e.pulse = m_pulse;
    e.flag  = m_flag;
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected record per clock edge, compared 1 ns after it.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        check({"level_", mname[m]}, level_o[m], e.level);
        check({"pulse_", mname[m]}, pulse_o[m], e.pulse[m]);
        check({"flag_",  mname[m]}, flag_o[m],  e.flag[m]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset state.
    rst = 1'b1; in_v = '0; clr = '0;
    step(3);
    rst = 1'b0;
    step(5);

    // Single rise then fall on channel 0.
    in_v[0] = 1'b1; step(20);
    in_v[0] = 1'b0; step(20);

    // Long high period on channel 3.
    in_v[3] = 1'b1; step(20);
    in_v[3] = 1'b0; step(20);

    // Short glitch on channel 1, then a glitch exactly DCYC long.
    in_v[1] = 1'b1; step(3);
    in_v[1] = 1'b0; step(15);
    in_v[1] = 1'b1; step(DB);
    in_v[1] = 1'b0; step(20);

    // Clear coinciding with pulse on channel 2, then clear alone.
    in_v[2] = 1'b1; step(S + DB);
    clr[2] = 1'b1; step(1);
    clr[2] = 1'b1; step(1);
    clr[2] = 1'b0; step(5);
    in_v[2] = 1'b0; step(20);
    clr = '1; step(1);
    clr = '0; step(2);

    // All inputs high through reset release, then reset mid-debounce.
    rst = 1'b1; in_v = '1; step(3);
    rst = 1'b0; step(S + DB + 6);
    in_v = '0; step(S + 1);
    rst = 1'b1; step(2);
    rst = 1'b0; step(20);

    // Randomised traffic with sparse clears and occasional resets.
    for (int t = 0; t < 500; t++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 7) == 0) in_v[c] = ~in_v[c];
      clr = W'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
      step(1);
    end
    clr = '0;
    step(S + DB + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
